// File: rtl/gray_pkg.sv
// Shared definitions for the gray-code receive blocks: FSM state encoding,
// default count width and a reference gray-to-binary conversion.
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } gray_state_t;

  // Binary bit i is the XOR of all gray bits at and above i.
  function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] g);
    logic [GRAY_WIDTH-1:0] b;
    b = g;
    for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary converter of arbitrary width.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Prefix XOR running from the MSB down.
  always_comb begin
    bin = gray;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_rx_decoder.sv
// Receives a gray-coded count stream, converts it to binary and classifies
// each step as stall, +1 (with wrap) or illegal, with a saturating error count.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  input  logic             clear_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_ok,
  output logic             wrap,
  output logic             stall,
  output logic             step_err,
  output logic             locked,
  output logic [ERRW-1:0]  err_count
);

  gray_state_t      state_r;
  logic [WIDTH-1:0] prev_bin_r;
  logic [WIDTH-1:0] new_bin_s;
  logic [WIDTH-1:0] delta_s;

  gray_to_bin #(.WIDTH(WIDTH)) u_conv (
    .gray (gray_in),
    .bin  (new_bin_s)
  );

  // Modular difference; wraps naturally at WIDTH bits.
  assign delta_s = new_bin_s - prev_bin_r;

  // Lock/classify FSM with registered pulses, level and error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= UNLOCKED;
      prev_bin_r <= {WIDTH{1'b0}};
      bin_out    <= {WIDTH{1'b0}};
      bin_valid  <= 1'b0;
      step_ok    <= 1'b0;
      wrap       <= 1'b0;
      stall      <= 1'b0;
      step_err   <= 1'b0;
      locked     <= 1'b0;
      err_count  <= {ERRW{1'b0}};
    end else begin
      bin_valid <= 1'b0;
      step_ok   <= 1'b0;
      wrap      <= 1'b0;
      stall     <= 1'b0;
      step_err  <= 1'b0;
      if (gray_valid) begin
        bin_out    <= new_bin_s;
        prev_bin_r <= new_bin_s;
        bin_valid  <= 1'b1;
      end else begin
        prev_bin_r <= prev_bin_r;
      end
      if (clear_err) begin
        // A sample arriving with the clear becomes the new lock point.
        err_count <= {ERRW{1'b0}};
        state_r   <= gray_valid ? LOCKED : UNLOCKED;
        locked    <= gray_valid;
      end else if (gray_valid) begin
        case (state_r)
          UNLOCKED: begin
            state_r <= LOCKED;
            locked  <= 1'b1;
          end
          LOCKED: begin
            if (delta_s == {WIDTH{1'b0}}) begin
              stall <= 1'b1;
            end else if (delta_s == WIDTH'(1)) begin
              step_ok <= 1'b1;
              wrap    <= (prev_bin_r == {WIDTH{1'b1}});
            end else begin
              step_err <= 1'b1;
              state_r  <= FAULT;
              locked   <= 1'b0;
              if (err_count != {ERRW{1'b1}}) begin
                err_count <= err_count + ERRW'(1);
              end else begin
                err_count <= err_count;
              end
            end
          end
          FAULT: begin
            state_r <= FAULT;
            locked  <= 1'b0;
          end
          default: begin
            state_r <= UNLOCKED;
            locked  <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
